// File: rtl/usb_dfu_pkg.sv
// Shared definitions for the DFU flash controller: FSM encoding, DFU bStatus
// codes, default flash geometry and the address range helper.
package usb_dfu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_READ       = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_WRITE      = 3'd4,
        ST_WRITE_BUSY = 3'd5,
        ST_DONE       = 3'd6
    } dfu_state_e;

    localparam logic [3:0] DFU_STATUS_OK          = 4'h0;
    localparam logic [3:0] DFU_STATUS_ERR_WRITE   = 4'h3;
    localparam logic [3:0] DFU_STATUS_ERR_ADDRESS = 4'h8;

    localparam int          DEF_PAGE_SIZE      = 256;
    localparam logic [15:0] DEF_BASE_PAGE      = 16'h0280;
    localparam logic [15:0] DEF_LIMIT_PAGE     = 16'h1000;
    localparam int          DEF_SETTLE_CYCLES  = 32;
    localparam logic [23:0] DEF_TIMEOUT_CYCLES = 24'd12000000;

    localparam int TIMER_W = 24;

    // A page is unusable if BASE_PAGE + block wrapped past 16 bits or landed
    // at or beyond the end of the DFU partition.
    function automatic logic addr_out_of_range(input logic        carry,
                                               input logic [15:0] addr,
                                               input logic [15:0] limit);
        return carry || (addr >= limit);
    endfunction

endpackage

// File: rtl/usb_flash_timer.sv
// Loadable down-counter shared by the SETTLE wait and the program/erase
// timeout. Loading N makes o_expired rise in the N-th cycle after the load.
module usb_flash_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    // Load on request, otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    // Expired in the last counted cycle (count of one) or when parked at zero.
    assign o_expired = (r_count[W-1:1] == '0);

endmodule

// File: rtl/usb_dfu_flash_ctrl.sv
// DFU block-to-flash-page controller: validates a DFU block request, drives
// the flash bridge read or write handshake for one page and reports bStatus.
module usb_dfu_flash_ctrl
    import usb_dfu_pkg::*;
#(
    parameter int          PAGE_SIZE      = DEF_PAGE_SIZE,
    parameter logic [15:0] BASE_PAGE      = DEF_BASE_PAGE,
    parameter logic [15:0] LIMIT_PAGE     = DEF_LIMIT_PAGE,
    parameter int          SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dfu_req,
    input  logic        dfu_dir,
    input  logic [15:0] dfu_block,
    input  logic [8:0]  dfu_len,
    output logic        dfu_busy,
    output logic        dfu_done,
    output logic [3:0]  dfu_status,
    output logic [15:0] flash_address,
    output logic        flash_rd_request,
    output logic        flash_wr_request,
    input  logic        flash_wr_busy,
    input  logic        flash_rd_data_put,
    input  logic        flash_wr_data_get
);

    localparam logic [8:0]         LP_PAGE_LEN = 9'(PAGE_SIZE);
    localparam logic [TIMER_W-1:0] LP_SETTLE   = TIMER_W'(SETTLE_CYCLES);

    dfu_state_e r_state;
    dfu_state_e w_next_state;

    logic               r_dir;
    logic [8:0]         r_len;
    logic [15:0]        r_addr;
    logic               r_addr_carry;
    logic [8:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_req;
    logic               r_wr_req;
    logic [3:0]         r_status;

    logic [16:0]        w_addr_sum;
    logic               w_addr_bad;
    logic               w_len_zero;
    logic               w_len_big;
    logic [8:0]         w_cnt_inc;
    logic               w_cnt_hit;
    logic               w_byte_pulse;
    logic               w_tmr_load;
    logic [TIMER_W-1:0] w_tmr_value;
    logic               w_tmr_expired;
    logic               w_status_upd;
    logic [3:0]         w_status_nxt;

    assign w_addr_sum   = {1'b0, BASE_PAGE} + {1'b0, dfu_block};
    assign w_addr_bad   = addr_out_of_range(r_addr_carry, r_addr, LIMIT_PAGE);
    assign w_len_zero   = (r_len == 9'd0);
    assign w_len_big    = (r_len > LP_PAGE_LEN);
    assign w_cnt_inc    = r_cnt + 9'd1;
    assign w_cnt_hit    = (w_cnt_inc == r_len);
    // Byte strobes only count while the matching transfer state is active.
    assign w_byte_pulse = ((r_state == ST_READ)  && flash_rd_data_put) ||
                          ((r_state == ST_WRITE) && flash_wr_data_get);

    usb_flash_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_tmr_load),
        .i_value   (w_tmr_value),
        .o_expired (w_tmr_expired)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; requests are only honoured in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (dfu_req) w_next_state = ST_CHECK;
                else         w_next_state = ST_IDLE;
            end
            ST_CHECK: begin
                if (w_addr_bad)      w_next_state = ST_DONE;
                else if (w_len_zero) w_next_state = ST_DONE;
                else if (w_len_big)  w_next_state = ST_DONE;
                else if (r_dir)      w_next_state = ST_WRITE;
                else                 w_next_state = ST_READ;
            end
            ST_READ: begin
                if (flash_rd_data_put && w_cnt_hit) w_next_state = ST_SETTLE;
                else                                w_next_state = ST_READ;
            end
            ST_SETTLE: begin
                if (w_tmr_expired) w_next_state = ST_DONE;
                else               w_next_state = ST_SETTLE;
            end
            ST_WRITE: begin
                if (flash_wr_data_get && w_cnt_hit) w_next_state = ST_WRITE_BUSY;
                else                                w_next_state = ST_WRITE;
            end
            ST_WRITE_BUSY: begin
                if (!flash_wr_busy)     w_next_state = ST_DONE;
                else if (w_tmr_expired) w_next_state = ST_DONE;
                else                    w_next_state = ST_WRITE_BUSY;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM output decode: timer loads on entry to SETTLE/WRITE_BUSY and status updates.
    always_comb begin
        w_tmr_load   = 1'b0;
        w_tmr_value  = LP_SETTLE;
        w_status_upd = 1'b0;
        w_status_nxt = r_status;
        case (r_state)
            ST_CHECK: begin
                if (w_addr_bad) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_ERR_ADDRESS;
                end else if (w_len_zero) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_OK;
                end else if (w_len_big) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_ERR_ADDRESS;
                end else begin
                    w_status_upd = 1'b0;
                end
            end
            ST_READ: begin
                if (w_next_state == ST_SETTLE) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = LP_SETTLE;
                end else begin
                    w_tmr_load  = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (w_tmr_expired) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_OK;
                end else begin
                    w_status_upd = 1'b0;
                end
            end
            ST_WRITE: begin
                if (w_next_state == ST_WRITE_BUSY) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = TIMEOUT_CYCLES;
                end else begin
                    w_tmr_load  = 1'b0;
                end
            end
            ST_WRITE_BUSY: begin
                if (!flash_wr_busy) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_OK;
                end else if (w_tmr_expired) begin
                    w_status_upd = 1'b1;
                    w_status_nxt = DFU_STATUS_ERR_WRITE;
                end else begin
                    w_status_upd = 1'b0;
                end
            end
            default: begin
                w_status_upd = 1'b0;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_status <= DFU_STATUS_OK;
        end else begin
            r_rd_req <= (w_next_state == ST_READ);
            r_wr_req <= (w_next_state == ST_WRITE);
            r_busy   <= (w_next_state != ST_IDLE);
            r_done   <= (w_next_state == ST_DONE);
            if (w_status_upd) r_status <= w_status_nxt;
            else              r_status <= r_status;
        end
    end

    // Request capture in IDLE and the per-page byte counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dir        <= 1'b0;
            r_len        <= 9'd0;
            r_addr       <= 16'h0000;
            r_addr_carry <= 1'b0;
            r_cnt        <= 9'd0;
        end else begin
            if ((r_state == ST_IDLE) && dfu_req) begin
                r_dir        <= dfu_dir;
                r_len        <= dfu_len;
                r_addr       <= w_addr_sum[15:0];
                r_addr_carry <= w_addr_sum[16];
            end else begin
                r_dir        <= r_dir;
                r_len        <= r_len;
                r_addr       <= r_addr;
                r_addr_carry <= r_addr_carry;
            end
            if (r_state == ST_CHECK) r_cnt <= 9'd0;
            else if (w_byte_pulse)   r_cnt <= w_cnt_inc;
            else                     r_cnt <= r_cnt;
        end
    end

    assign dfu_busy         = r_busy;
    assign dfu_done         = r_done;
    assign dfu_status       = r_status;
    assign flash_address    = r_addr;
    assign flash_rd_request = r_rd_req;
    assign flash_wr_request = r_wr_req;

endmodule
